// File: rtl/serial_link_data_link_chmask.sv
// Serial link data link layer with runtime channel masking.
// TX splits a payload into beats over the enabled PHY channels only, and RX
// reassembles beats from the same channel set back into a payload.
// Optional statistics counters: define SERIAL_LINK_DATA_LINK_STATS_EN.
module serial_link_data_link_chmask #(
  parameter int unsigned NumChannels  = 4,
  parameter int unsigned ChanWidth    = 16,
  parameter int unsigned PayloadWidth = 128
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [PayloadWidth-1:0]          payload_in_i,
  input  logic                             payload_in_valid_i,
  output logic                             payload_in_ready_o,
  output logic [PayloadWidth-1:0]          payload_out_o,
  output logic                             payload_out_valid_o,
  input  logic                             payload_out_ready_i,
  output logic [NumChannels*ChanWidth-1:0] data_out_o,
  output logic [NumChannels-1:0]           data_out_valid_o,
  input  logic                             data_out_ready_i,
  input  logic [NumChannels*ChanWidth-1:0] data_in_i,
  input  logic [NumChannels-1:0]           data_in_valid_i,
  output logic [NumChannels-1:0]           data_in_ready_o,
  input  logic [NumChannels-1:0]           cfg_ch_en_i,
  input  logic                             cfg_flush_i,
  output logic                             tx_busy_o,
  output logic                             rx_busy_o
`ifdef SERIAL_LINK_DATA_LINK_STATS_EN
  ,
  output logic [31:0]                      stat_tx_payloads_o,
  output logic [31:0]                      stat_rx_payloads_o,
  output logic [31:0]                      stat_tx_stall_o
`endif
);

  // Chunk = ChanWidth bits. The payload spans MaxChunks chunks; the last beat
  // may reach up to NumChannels chunks past that (padding).
  localparam int unsigned MaxChunks = (PayloadWidth + ChanWidth - 1) / ChanWidth;
  localparam int unsigned TotChunks = MaxChunks + NumChannels;
  localparam int unsigned BeatW     = $clog2(MaxChunks + 1);
  localparam int unsigned CntW      = $clog2(NumChannels + 1);
  localparam int unsigned ChunkIdxW = $clog2(TotChunks);
  localparam int unsigned BufIdxW   = (MaxChunks > 1) ? $clog2(MaxChunks) : 1;

  typedef logic [NumChannels:0][BeatW-1:0] ntable_t;

  // Beats per payload for every enabled-channel count K (entry 0 unused).
  function automatic ntable_t build_ntable();
    ntable_t t;
    t[0] = BeatW'(1'b1);
    for (int k = 1; k <= int'(NumChannels); k++) begin
      t[k] = BeatW'((PayloadWidth + k * ChanWidth - 1) / (k * ChanWidth));
    end
    return t;
  endfunction

  localparam ntable_t NTable = build_ntable();

  // Number of set mask bits strictly below channel index lim.
  function automatic logic [CntW-1:0] count_below(input logic [NumChannels-1:0] m,
                                                  input int unsigned lim);
    logic [CntW-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      if (i < lim && m[i]) cnt = cnt + CntW'(1'b1);
      else                 cnt = cnt;
    end
    return cnt;
  endfunction

  typedef enum logic { TxIdle, TxSend } tx_state_e;
  typedef enum logic { RxIdle, RxAssemble } rx_state_e;

  tx_state_e                      tx_state_q;
  logic [BeatW-1:0]               tx_beat_q;
  logic [NumChannels-1:0]         tx_mask_q;
  logic [NumChannels-1:0]         tx_mask_s;
  logic [CntW-1:0]                tx_k_s;
  logic [BeatW-1:0]               tx_n_s;
  logic                           tx_last_s, tx_active_s, tx_fire_s;
  logic [TotChunks*ChanWidth-1:0] tx_padded_s;
  logic [ChanWidth-1:0]           tx_chunk_s [TotChunks];

  rx_state_e                      rx_state_q;
  logic [BeatW-1:0]               rx_beat_q;
  logic [NumChannels-1:0]         rx_mask_q;
  logic [NumChannels-1:0]         rx_mask_s;
  logic [CntW-1:0]                rx_k_s;
  logic [BeatW-1:0]               rx_n_s;
  logic                           rx_last_s, rx_fire_s;
  logic [ChanWidth-1:0]           rx_buf_q [MaxChunks];
  logic [ChanWidth-1:0]           rx_buf_d [MaxChunks];
  logic [MaxChunks*ChanWidth-1:0] rx_flat_s;
  logic [PayloadWidth-1:0]        payload_out_q;
  logic                           payload_out_valid_q;

  // TX control: live mask while idle, latched mask once a payload is in flight.
  always_comb begin
    tx_mask_s   = (tx_state_q == TxIdle) ? cfg_ch_en_i : tx_mask_q;
    tx_k_s      = count_below(tx_mask_s, NumChannels);
    tx_n_s      = NTable[tx_k_s];
    tx_last_s   = (tx_beat_q == tx_n_s - BeatW'(1'b1));
    tx_active_s = !cfg_flush_i && (|tx_mask_s) &&
                  ((tx_state_q == TxSend) || payload_in_valid_i);
    tx_fire_s   = tx_active_s && data_out_ready_i;
  end

  // Zero-pad the payload so that a partial last beat reads zeros.
  always_comb begin
    tx_padded_s = {{(TotChunks*ChanWidth-PayloadWidth){1'b0}}, payload_in_i};
    for (int unsigned i = 0; i < TotChunks; i++) begin
      tx_chunk_s[i] = tx_padded_s[i*ChanWidth +: ChanWidth];
    end
  end

  // TX lane mapping: the j-th enabled channel carries chunk beat*K + j.
  always_comb begin
    logic [ChunkIdxW-1:0] idx;
    data_out_o = '0;
    idx        = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (tx_active_s && tx_mask_s[c]) begin
        idx = ChunkIdxW'(tx_beat_q) * ChunkIdxW'(tx_k_s) +
              ChunkIdxW'(count_below(tx_mask_s, c));
        data_out_o[c*ChanWidth +: ChanWidth] = tx_chunk_s[idx];
      end else begin
        data_out_o[c*ChanWidth +: ChanWidth] = '0;
      end
    end
  end

  assign data_out_valid_o   = tx_active_s ? tx_mask_s : '0;
  assign payload_in_ready_o = tx_fire_s && tx_last_s;
  assign tx_busy_o          = (tx_state_q == TxSend);

  // TX FSM: beat sequencing, mask latching and abort on flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TxIdle;
      tx_beat_q  <= '0;
      tx_mask_q  <= '0;
    end else if (cfg_flush_i) begin
      tx_state_q <= TxIdle;
      tx_beat_q  <= '0;
      tx_mask_q  <= '0;
    end else if (tx_fire_s && tx_last_s) begin
      tx_state_q <= TxIdle;
      tx_beat_q  <= '0;
    end else if (tx_fire_s) begin
      if (tx_state_q == TxIdle) tx_mask_q <= cfg_ch_en_i;
      else                      tx_mask_q <= tx_mask_q;
      tx_state_q <= TxSend;
      tx_beat_q  <= tx_beat_q + BeatW'(1'b1);
    end else begin
      tx_state_q <= tx_state_q;
    end
  end

  // RX control: accept a beat when all enabled lanes are valid and, for the
  // last beat, the output register is free or being drained this cycle.
  always_comb begin
    rx_mask_s = (rx_state_q == RxIdle) ? cfg_ch_en_i : rx_mask_q;
    rx_k_s    = count_below(rx_mask_s, NumChannels);
    rx_n_s    = NTable[rx_k_s];
    rx_last_s = (rx_beat_q == rx_n_s - BeatW'(1'b1));
    rx_fire_s = !cfg_flush_i && (|rx_mask_s) &&
                ((data_in_valid_i & rx_mask_s) == rx_mask_s) &&
                (!rx_last_s || !payload_out_valid_q || payload_out_ready_i);
  end

  assign data_in_ready_o = rx_fire_s ? rx_mask_s : '0;
  assign rx_busy_o       = (rx_state_q == RxAssemble);

  // RX assembly view including the current beat; pad chunks are dropped.
  always_comb begin
    logic [ChunkIdxW-1:0] idx;
    rx_buf_d = rx_buf_q;
    idx      = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (rx_mask_s[c]) begin
        idx = ChunkIdxW'(rx_beat_q) * ChunkIdxW'(rx_k_s) +
              ChunkIdxW'(count_below(rx_mask_s, c));
        if (idx < ChunkIdxW'(MaxChunks)) rx_buf_d[BufIdxW'(idx)] = data_in_i[c*ChanWidth +: ChanWidth];
        else                             idx = idx;
      end else begin
        idx = idx;
      end
    end
    for (int unsigned i = 0; i < MaxChunks; i++) begin
      rx_flat_s[i*ChanWidth +: ChanWidth] = rx_buf_d[i];
    end
  end

  // RX FSM: beat counting, mask latching and output valid handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q          <= RxIdle;
      rx_beat_q           <= '0;
      rx_mask_q           <= '0;
      payload_out_valid_q <= 1'b0;
    end else if (cfg_flush_i) begin
      rx_state_q          <= RxIdle;
      rx_beat_q           <= '0;
      rx_mask_q           <= '0;
      payload_out_valid_q <= 1'b0;
    end else begin
      if (rx_fire_s && rx_last_s) begin
        rx_state_q <= RxIdle;
        rx_beat_q  <= '0;
      end else if (rx_fire_s) begin
        if (rx_state_q == RxIdle) rx_mask_q <= cfg_ch_en_i;
        else                      rx_mask_q <= rx_mask_q;
        rx_state_q <= RxAssemble;
        rx_beat_q  <= rx_beat_q + BeatW'(1'b1);
      end else begin
        rx_state_q <= rx_state_q;
      end
      if (rx_fire_s && rx_last_s)    payload_out_valid_q <= 1'b1;
      else if (payload_out_ready_i)  payload_out_valid_q <= 1'b0;
      else                           payload_out_valid_q <= payload_out_valid_q;
    end
  end

  // RX datapath: assembly buffer and output payload register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MaxChunks; i++) rx_buf_q[i] <= '0;
      payload_out_q <= '0;
    end else if (rx_fire_s) begin
      rx_buf_q <= rx_buf_d;
      if (rx_last_s) payload_out_q <= rx_flat_s[PayloadWidth-1:0];
      else           payload_out_q <= payload_out_q;
    end else begin
      payload_out_q <= payload_out_q;
    end
  end

  assign payload_out_o       = payload_out_q;
  assign payload_out_valid_o = payload_out_valid_q;

`ifdef SERIAL_LINK_DATA_LINK_STATS_EN
  logic [31:0] stat_tx_payloads_q, stat_rx_payloads_q, stat_tx_stall_q;

  // Free-running wrapping statistics counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_tx_payloads_q <= 32'd0;
      stat_rx_payloads_q <= 32'd0;
      stat_tx_stall_q    <= 32'd0;
    end else if (cfg_flush_i) begin
      stat_tx_payloads_q <= 32'd0;
      stat_rx_payloads_q <= 32'd0;
      stat_tx_stall_q    <= 32'd0;
    end else begin
      if (payload_in_ready_o) stat_tx_payloads_q <= stat_tx_payloads_q + 32'd1;
      else                    stat_tx_payloads_q <= stat_tx_payloads_q;
      if (payload_out_valid_q && payload_out_ready_i) stat_rx_payloads_q <= stat_rx_payloads_q + 32'd1;
      else                                            stat_rx_payloads_q <= stat_rx_payloads_q;
      if (tx_active_s && !data_out_ready_i) stat_tx_stall_q <= stat_tx_stall_q + 32'd1;
      else                                  stat_tx_stall_q <= stat_tx_stall_q;
    end
  end

  assign stat_tx_payloads_o = stat_tx_payloads_q;
  assign stat_rx_payloads_o = stat_rx_payloads_q;
  assign stat_tx_stall_o    = stat_tx_stall_q;
`endif

endmodule
